data_memory: RTL
================

Name: data_memory

Overview:
- Parametrised synchronous single-port data memory for the CPU, superseding the basic word memory.
- Adds byte-lane write enables, a valid/ready request interface, a configurable read-latency pipeline, out-of-range detection, and an optional post-reset clear sequencer.
- Sits between the CPU load/store stage and on-chip storage; sustains one request per cycle once ready.

Parameters:
- addresswidth, 8, word-address bits.
- depth, 2**addresswidth, number of implemented words; must be ≤ 2**addresswidth.
- width, 32, data word bits; must be a multiple of 8.
- readlatency, 1, cycles from accepted read to response; legal range 1..4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_write  input  1  1 = write, 0 = read.
- req_address  input  addresswidth  word address.
- req_byteen  input  width/8  byte-lane write enables; ignored for reads.
- req_dataIn  input  width  write data.
- resp_valid  output  1  read data valid; single-cycle pulse per read.
- resp_dataOut  output  width  read data.
- resp_error  output  1  qualifies resp_valid: the read address was ≥ depth.
- busy  output  1  clear sequence in progress.

Behaviour:
- Reset: asynchronous, active-low.
  - Pipeline valid bits, resp_valid, resp_error and resp_dataOut go to 0.
  - The clear counter goes to 0.
  - req_ready = 0 while reset_n is low.
  - Array contents are not touched by reset itself.
- State machine: INIT and RUN.
  - Reset enters INIT if the clear feature is compiled in; otherwise it enters RUN.
  - INIT: write all-zero to word clear_cnt each cycle and increment the counter. busy = 1, req_ready = 0.
  - After word depth-1 is written, go to RUN on the next edge. INIT takes exactly depth cycles.
  - RUN: busy = 0, req_ready = 1. RUN is never left except through reset.
- Handshake: a request is accepted on a rising edge where req_valid & req_ready are both 1. There is no response backpressure.
- Write, when accepted:
  - For each lane i with req_byteen[i] = 1, set mem[addr][8i+7:8i] = req_dataIn[8i+7:8i].
  - Lanes with req_byteen[i] = 0 keep their value. All-zero byteen is a no-op.
  - Writes produce no response.
- Read, when accepted: resp_valid pulses exactly readlatency cycles after the accept edge.
  - readlatency = 1: data is registered at the accept edge and appears the following cycle.
  - Each extra stage adds one register.
  - Back-to-back reads return back-to-back responses in order.
- Ordering: a read accepted the cycle after a write to the same address returns the newly written data. Each cycle holds exactly one access, so no read/write collision exists.
- Out-of-range (address ≥ depth; only possible when depth < 2**addresswidth):
  - Writes are dropped.
  - Reads return resp_dataOut = 0 with resp_error = 1.
  - Otherwise resp_error = 0.
- resp_dataOut holds its last value when resp_valid = 0.
- Reset mid-operation:
  - In-flight reads are discarded; no resp_valid is produced for them.
  - Reset during INIT restarts the clear at word 0 after release.
  - A write accepted before reset is either fully applied or not applied; it is never partially applied.

Optional Feature:
- Macro: DATA_MEMORY_CLEAR_EN.
- Defined: the INIT clear sequencer exists. Every word reads as 0 until it is written. busy is high for depth cycles after each reset release.
- Undefined: no sequencer. req_ready = 1 from the first edge after reset release, busy is tied to 0, and the contents of never-written words are unspecified.

Test Plan:
All scenarios use width=32, addresswidth=8, depth=256, readlatency=2 unless noted.
1. Clear defined, release reset -> busy = 1 and req_ready = 0 for 256 cycles, then req_ready = 1. Reading addr 0x7F then returns 0x00000000.
2. Write 0x11223344 to addr 5 with byteen=1111, then write 0xAABBCCDD to addr 5 with byteen=0101, then read addr 5 -> resp_dataOut = 0x11BB33DD, resp_valid exactly 2 cycles after the accept.
3. Reads of addr 1, 2, 3 on consecutive cycles, holding 0xA, 0xB, 0xC -> three consecutive resp_valid pulses with data 0xA, 0xB, 0xC in order. Repeat with readlatency=1 and readlatency=4 -> pulses shift by 1 and 4 cycles respectively.
4. depth=200: write 0xDEADBEEF to addr 210, then read addr 210 -> resp_dataOut = 0, resp_error = 1. Read addr 199 -> resp_error = 0.
5. Write 0x55 to addr 9 and read addr 9 on the next cycle -> returns 0x00000055.
6. Assert reset_n = 0 with two reads in flight, and separately at clear count 100 -> no resp_valid for the in-flight reads. After release, busy stays high for a full 256 cycles.

Source files
------------

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//
// Synchronous single-port data memory for the CPU load/store stage.
// Supports byte-lane write enables and a valid/ready request interface. Reads
// return through a response pipeline of configurable depth. Accesses at or
// beyond 'depth' are detected and flagged. An optional post-reset clear
// sequencer zeroes every word.
//
// Optional feature macro: DATA_MEMORY_CLEAR_EN
//   defined   -> after each reset release the INIT state writes zero to every
//                word (depth cycles, busy = 1, req_ready = 0).
//   undefined -> no clear; req_ready rises on the first edge after release,
//                busy stays 0, unwritten words hold unspecified data.
//
// Parameters:
//   addresswidth : word-address bits
//   depth        : implemented words (<= 2**addresswidth)
//   width        : data bits (multiple of 8)
//   readlatency  : accept-to-response cycles (1..4)
//
// Ports:
//   clk          : clock, rising edge
//   reset_n      : asynchronous active-low reset
//   req_valid    : request present
//   req_ready    : request can be accepted this cycle
//   req_write    : 1 = write, 0 = read
//   req_address  : word address
//   req_byteen   : byte-lane write enables (ignored for reads)
//   req_dataIn   : write data
//   resp_valid   : one-cycle pulse per accepted read
//   resp_dataOut : read data, holds between responses
//   resp_error   : read address was out of range (data forced to 0)
//   busy         : clear sequence in progress
// -----------------------------------------------------------------------------
module data_memory #(
   parameter int addresswidth = 8,
   parameter int depth        = 2**addresswidth,
   parameter int width        = 32,
   parameter int readlatency  = 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [addresswidth-1:0]   req_address,
   input  logic [width/8-1:0]        req_byteen,
   input  logic [width-1:0]          req_dataIn,
   output logic                      resp_valid,
   output logic [width-1:0]          resp_dataOut,
   output logic                      resp_error,
   output logic                      busy
);

   localparam int lanes = width / 8;
   localparam logic [addresswidth-1:0] last_word = addresswidth'(depth - 1);

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

`ifdef DATA_MEMORY_CLEAR_EN
   localparam state_t reset_state = INIT;
   localparam logic   reset_busy  = 1'b1;
`else
   localparam state_t reset_state = RUN;
   localparam logic   reset_busy  = 1'b0;
`endif

   state_t                  state_r;
   logic                    ready_r;
   logic                    busy_r;
   logic [addresswidth-1:0] clear_cnt_r;

   logic [width-1:0]        mem [0:depth-1];

   logic [readlatency-1:0]  pipe_valid_r;
   logic [readlatency-1:0]  pipe_error_r;
   logic [width-1:0]        pipe_data_r [readlatency];

   logic                    accept_s;
   logic                    in_range_s;
   logic                    wr_s;
   logic                    rd_s;
   logic                    clear_we_s;
   logic [31:0]             addr_ext_s;
   logic [width-1:0]        rd_data_s;

   // Request decode: handshake, range check and read-data selection
   always_comb begin
      addr_ext_s = 32'(req_address);
      accept_s   = req_valid & ready_r;
      in_range_s = (addr_ext_s < 32'(depth));
      // out-of-range writes are dropped here, never reach the array
      wr_s       = accept_s & req_write & in_range_s;
      rd_s       = accept_s & ~req_write;
      // the clear must not touch the array while reset is held
      clear_we_s = (state_r == INIT) & reset_n;
      rd_data_s  = in_range_s ? mem[req_address] : {width{1'b0}};
   end

   // Control FSM: clear sequencing and registered ready/busy
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= reset_state;
         busy_r      <= reset_busy;
         ready_r     <= 1'b0;
         clear_cnt_r <= '0;
      end else begin
         case (state_r)
            INIT: begin
               clear_cnt_r <= clear_cnt_r + addresswidth'(1);
               if (clear_cnt_r == last_word) begin
                  // final word is cleared on this edge; open for requests next cycle
                  state_r <= RUN;
                  busy_r  <= 1'b0;
                  ready_r <= 1'b1;
               end else begin
                  state_r <= INIT;
                  busy_r  <= 1'b1;
                  ready_r <= 1'b0;
               end
            end
            RUN: begin
               state_r <= RUN;
               busy_r  <= 1'b0;
               ready_r <= 1'b1;
            end
            default: begin
               state_r     <= reset_state;
               busy_r      <= reset_busy;
               ready_r     <= 1'b0;
               clear_cnt_r <= '0;
            end
         endcase
      end
   end

   // Storage array: clear writes and byte-lane request writes; contents are not reset
   always_ff @(posedge clk) begin
      if (clear_we_s) begin
         mem[clear_cnt_r] <= {width{1'b0}};
      end else if (wr_s) begin
         for (int i = 0; i < lanes; i++) begin
            if (req_byteen[i]) begin
               mem[req_address][8*i +: 8] <= req_dataIn[8*i +: 8];
            end
         end
      end
   end

   // Read response pipeline: stage 0 captures at the accept edge, the last stage drives the outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pipe_valid_r <= '0;
         pipe_error_r <= '0;
         for (int s = 0; s < readlatency; s++) begin
            pipe_data_r[s] <= {width{1'b0}};
         end
      end else begin
         pipe_valid_r[0] <= rd_s;
         pipe_error_r[0] <= rd_s & ~in_range_s;
         // data registers only load with a valid read so the output holds between responses
         if (rd_s) begin
            pipe_data_r[0] <= rd_data_s;
         end
         for (int s = 1; s < readlatency; s++) begin
            pipe_valid_r[s] <= pipe_valid_r[s-1];
            pipe_error_r[s] <= pipe_error_r[s-1];
            if (pipe_valid_r[s-1]) begin
               pipe_data_r[s] <= pipe_data_r[s-1];
            end
         end
      end
   end

   assign req_ready    = ready_r;
   assign busy         = busy_r;
   assign resp_valid   = pipe_valid_r[readlatency-1];
   assign resp_error   = pipe_error_r[readlatency-1];
   assign resp_dataOut = pipe_data_r[readlatency-1];

endmodule
